ofm_sram_arb: RTL and testbench

OFM_SRAM_ARB -- requirements
Module: ofm_sram_arb

---
 rtl/ofm_sram_arb.sv | 162 ++++++++++++++++
 tb/tb_ofm_sram_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_sram_arb.sv
// OFM SRAM arbiter: buffers conv writes in a small FIFO, forwards buffered data to
// previous-result reads, and serves sequential host readout from a single-port SRAM.
module ofm_sram_arb #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 11,
  parameter int unsigned OFM_DEPTH  = 784,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  wr_req,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  prv_req,
  input  logic [ADDR_BITS-1:0]  prv_addr,
  output logic                  prv_valid,
  output logic [DATA_WIDTH-1:0] prv_data,
  input  logic                  host_req,
  input  logic                  host_rewind,
  output logic                  host_valid,
  output logic [31:0]           host_data,
  output logic [ADDR_BITS-1:0]  host_ptr,
  output logic                  sram_we,
  output logic [ADDR_BITS-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  wr_pending,
  output logic                  wr_overflow
);

  localparam int unsigned PW = $clog2(WBUF_DEPTH);

  typedef enum logic [1:0] {H_IDLE, H_WAIT, H_DATA, H_HOLD} hst_e;

  logic [ADDR_BITS-1:0]  fa_q [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] fd_q [WBUF_DEPTH];
  logic [PW:0]           wp_q, rp_q, cnt;
  logic [PW-1:0]         head;
  logic                  fifo_ne, fifo_full, push, pop, ovf_q;

  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data, fwd_q;
  logic                  fwd_sel_q, prv_valid_q, prv_rd, host_rd;

  hst_e                  hst_q, hst_d;
  logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
  logic                  hv_q, hv_d;
  logic [31:0]           hd_q, hd_d;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign cnt       = wp_q - rp_q;
  assign head      = rp_q[PW-1:0];
  assign fifo_ne   = (cnt != '0);
  assign fifo_full = (cnt == (PW+1)'(WBUF_DEPTH));

  // Oldest-to-youngest scan so the last match wins; a same-cycle write is younger still.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      if (((PW+1)'(i) < cnt) && (fa_q[head + PW'(i)] == prv_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = fd_q[head + PW'(i)];
      end
    end
    if (wr_req && (wr_addr == prv_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = wr_data;
    end
  end

  assign prv_rd  = prv_req & ~fwd_hit;
  assign pop     = fifo_ne & ~prv_rd;
  assign host_rd = (hst_q == H_WAIT) & ~prv_rd & ~fifo_ne & ~host_rewind;
  assign push    = wr_req & (~fifo_full | pop);

  always_comb begin
    sram_we    = pop;
    sram_addr  = addr_q;
    sram_wdata = wdata_q;
    if (prv_rd) begin
      sram_addr = prv_addr;
    end else if (pop) begin
      sram_addr  = fa_q[head];
      sram_wdata = fd_q[head];
    end else if (host_rd) begin
      sram_addr = ptr_q;
    end
  end

  always_comb begin
    hst_d = hst_q;
    ptr_d = ptr_q;
    hv_d  = 1'b0;
    hd_d  = hd_q;
    unique case (hst_q)
      H_IDLE: if (host_req) hst_d = H_WAIT;
      H_WAIT: if (host_rd) hst_d = H_DATA;
      H_DATA: begin
        hv_d  = 1'b1;
        hd_d  = 32'(sram_rdata);
        ptr_d = (ptr_q == ADDR_BITS'(OFM_DEPTH - 1)) ? '0 : ptr_q + ADDR_BITS'(1);
        hst_d = H_HOLD;
      end
      H_HOLD: hst_d = H_IDLE;
      default: hst_d = H_IDLE;
    endcase
    if (host_rewind) begin
      hst_d = H_IDLE;
      ptr_d = '0;
      hv_d  = 1'b0;
      hd_d  = hd_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      fa_q[wp_q[PW-1:0]] <= wr_addr;
      fd_q[wp_q[PW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wp_q        <= '0;
      rp_q        <= '0;
      ovf_q       <= 1'b0;
      prv_valid_q <= 1'b0;
      fwd_sel_q   <= 1'b0;
      fwd_q       <= '0;
      hst_q       <= H_IDLE;
      ptr_q       <= '0;
      hv_q        <= 1'b0;
      hd_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      if (push) wp_q <= wp_q + (PW+1)'(1);
      if (pop)  rp_q <= rp_q + (PW+1)'(1);
      if (wr_req && fifo_full && !pop) ovf_q <= 1'b1;
      prv_valid_q <= prv_req;
      fwd_sel_q   <= fwd_hit;
      if (fwd_hit) fwd_q <= fwd_data;
      hst_q   <= hst_d;
      ptr_q   <= ptr_d;
      hv_q    <= hv_d;
      hd_q    <= hd_d;
      addr_q  <= sram_addr;
      wdata_q <= sram_wdata;
    end
  end

  assign prv_valid   = prv_valid_q;
  assign prv_data    = !prv_valid_q ? '0 : (fwd_sel_q ? fwd_q : sram_rdata);
  assign host_valid  = hv_q;
  assign host_data   = hd_q;
  assign host_ptr    = ptr_q;
  assign wr_pending  = fifo_ne;
  assign wr_overflow = ovf_q;

endmodule

// File: tb/tb_ofm_sram_arb.sv
// Scoreboard bench for ofm_sram_arb: stimulus pushes expected responses, a negedge
// monitor pops and compares SRAM writes, previous-result returns and host returns.
module tb_ofm_sram_arb;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        wr_req, prv_req, host_req, host_rewind;
  logic [10:0] wr_addr, prv_addr;
  logic [7:0]  wr_data;
  logic        prv_valid, host_valid, sram_we, wr_pending, wr_overflow;
  logic [7:0]  prv_data, sram_wdata, sram_rdata;
  logic [31:0] host_data;
  logic [10:0] host_ptr, sram_addr;

  logic [7:0]  mem    [2048];
  logic [7:0]  golden [2048];

  logic [31:0] wr_exp[$];
  logic [31:0] prv_exp[$];
  logic [31:0] host_exp[$];

  int tests = 0;
  int fails = 0;

  always #5 HCLK = ~HCLK;

  ofm_sram_arb #(
    .DATA_WIDTH(8), .ADDR_BITS(11), .OFM_DEPTH(784), .WBUF_DEPTH(4)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .prv_req(prv_req), .prv_addr(prv_addr),
    .prv_valid(prv_valid), .prv_data(prv_data),
    .host_req(host_req), .host_rewind(host_rewind),
    .host_valid(host_valid), .host_data(host_data), .host_ptr(host_ptr),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .wr_pending(wr_pending), .wr_overflow(wr_overflow)
  );

  // Single-port SRAM model with one cycle of read latency.
  always @(posedge HCLK) begin
    sram_rdata <= mem[sram_addr];
    if (sram_we) mem[sram_addr] <= sram_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (HRESETn === 1'b1) begin
      if (sram_we) begin
        if (wr_exp.size() == 0) chk("sram_write_unexpected", sram_we, 1'b0);
        else chk("sram_write", {13'd0, sram_addr, sram_wdata}, wr_exp.pop_front());
      end
      if (prv_valid) begin
        if (prv_exp.size() == 0) chk("prv_valid_unexpected", prv_valid, 1'b0);
        else chk("prv_data", {24'd0, prv_data}, prv_exp.pop_front());
      end
      if (host_valid) begin
        if (host_exp.size() == 0) chk("host_valid_unexpected", host_valid, 1'b0);
        else chk("host_data", host_data, host_exp.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic neg();
    @(negedge HCLK);
  endtask

  task automatic idle();
    wr_req = 1'b0; prv_req = 1'b0; host_req = 1'b0; host_rewind = 1'b0;
  endtask

  task automatic drive_wr(input int a, input int d, input bit ok);
    wr_req = 1'b1; wr_addr = 11'(a); wr_data = 8'(d);
    if (ok) begin
      wr_exp.push_back({13'd0, 11'(a), 8'(d)});
      golden[a] = 8'(d);
    end
  endtask

  task automatic drive_prv(input int a, input logic [7:0] e);
    prv_req = 1'b1; prv_addr = 11'(a);
    prv_exp.push_back({24'd0, e});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sram_we"},    sram_we,    1'b0);
    chk({tag, "_sram_addr"},  sram_addr,  '0);
    chk({tag, "_sram_wdata"}, sram_wdata, '0);
    chk({tag, "_prv_valid"},  prv_valid,  1'b0);
    chk({tag, "_prv_data"},   prv_data,   '0);
    chk({tag, "_host_valid"}, host_valid, 1'b0);
    chk({tag, "_host_data"},  host_data,  '0);
    chk({tag, "_host_ptr"},   host_ptr,   '0);
    chk({tag, "_pending"},    wr_pending, 1'b0);
    chk({tag, "_overflow"},   wr_overflow, 1'b0);
  endtask

  initial begin
    int nv;
    int cyc;
    int hv;
    int nwe;
    for (int a = 0; a < 2048; a++) begin
      mem[a]    = 8'(a) ^ 8'h5A;
      golden[a] = 8'(a) ^ 8'h5A;
    end
    HRESETn = 1'b0;
    idle();
    wr_addr = '0; wr_data = '0; prv_addr = '0;
    #12;
    chk_reset_outputs("rst0");
    step();
    HRESETn = 1'b1;

    // Three back-to-back writes drain one cycle later, in order.
    step(); drive_wr(5, 'h11, 1'b1); neg(); chk("A_we_c0", sram_we, 1'b0);
    step(); drive_wr(6, 'h22, 1'b1); neg(); chk("A_we_c1", sram_we, 1'b1);
    step(); drive_wr(7, 'h33, 1'b1); neg(); chk("A_we_c2", sram_we, 1'b1);
    step(); wr_req = 1'b0;           neg(); chk("A_we_c3", sram_we, 1'b1);
    step(); neg(); chk("A_we_c4", sram_we, 1'b0); chk("A_pending_low", wr_pending, 1'b0);

    // Continuous prv reads starve the drain; fifth write overflows.
    for (int i = 0; i < 6; i++) begin
      step();
      drive_prv(100 + i, golden[100 + i]);
      if (i < 5) drive_wr(20 + i, 'hC0 + i, i < 4);
      else wr_req = 1'b0;
      neg();
      chk("B_no_we", sram_we, 1'b0);
      if (i >= 1) chk("B_prv_valid", prv_valid, 1'b1);
      if (i == 5) chk("B_overflow", wr_overflow, 1'b1);
    end
    step(); idle(); neg();
    chk("B_drain_start", sram_we, 1'b1); chk("B_prv_valid_last", prv_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(); neg(); chk("B_drain", sram_we, 1'b1);
    end
    step(); neg(); chk("B_drain_done", sram_we, 1'b0); chk("B_pending_low", wr_pending, 1'b0);

    // Forwarding: youngest FIFO entry, same-cycle write, then SRAM after drain.
    step(); drive_prv(200, 8'h92); drive_wr(30, 'h01, 1'b1); neg();
    step(); drive_prv(201, 8'h93); drive_wr(30, 'h02, 1'b1); neg();
    chk("C_we_blocked", sram_we, 1'b0);
    step(); drive_prv(30, 8'h02); wr_req = 1'b0; neg();
    chk("C_drain_on_hit", sram_we, 1'b1); chk("C_drain_addr", sram_addr, 11'd30);
    step(); drive_prv(30, 8'h03); drive_wr(30, 'h03, 1'b1); neg();
    step(); drive_prv(30, 8'h03); wr_req = 1'b0; neg();
    step(); drive_prv(30, 8'h03); neg(); chk("C_sram_read", sram_we, 1'b0);
    step(); idle(); drive_wr(9, 'hA5, 1'b1); neg();
    step(); wr_req = 1'b0; drive_prv(9, 8'hA5); neg(); chk("C_no_read_of_9", sram_we, 1'b1);
    step(); idle(); neg(); chk("C_fwd_valid", prv_valid, 1'b1);
    step(); neg();

    // Host readout over the whole OFM, wrapping at the last word.
    step(); host_req = 1'b1;
    for (int p = 0; p < 784; p++) host_exp.push_back({24'd0, golden[p]});
    nv = 0;
    cyc = 0;
    while (nv < 784 && cyc < 5000) begin
      neg();
      if (host_valid) begin
        nv++;
        if (nv == 783) chk("D_ptr_783", host_ptr, 11'd783);
        if (nv == 784) chk("D_ptr_wrap", host_ptr, 11'd0);
      end
      cyc++;
    end
    chk("D_host_reads", nv, 784);
    step(); host_req = 1'b0;

    // Host read waits for the write buffer to empty.
    neg();
    step(); drive_wr(40, 'h40, 1'b1); host_req = 1'b1;
    host_exp.push_back({24'd0, golden[0]});
    neg();
    step(); host_req = 1'b0; drive_wr(41, 'h41, 1'b1); neg();
    chk("E_pending_c1", wr_pending, 1'b1); chk("E_we_c1", sram_we, 1'b1);
    step(); drive_wr(42, 'h42, 1'b1); neg();
    chk("E_pending_c2", wr_pending, 1'b1); chk("E_we_c2", sram_we, 1'b1);
    step(); wr_req = 1'b0; neg();
    chk("E_pending_c3", wr_pending, 1'b1); chk("E_we_c3", sram_we, 1'b1);
    step(); neg();
    chk("E_pending_c4", wr_pending, 1'b0); chk("E_we_c4", sram_we, 1'b0);
    chk("E_host_addr", sram_addr, 11'd0);
    step(); neg();
    step(); neg(); chk("E_host_valid", host_valid, 1'b1); chk("E_ptr_inc", host_ptr, 11'd1);

    // Rewind while waiting cancels the read.
    step(); idle(); host_req = 1'b1; drive_wr(43, 'h43, 1'b1); neg();
    step(); host_req = 1'b0; host_rewind = 1'b1; drive_wr(44, 'h44, 1'b1); neg();
    step(); host_rewind = 1'b0; wr_req = 1'b0; neg(); chk("E_rewind_ptr", host_ptr, 11'd0);
    hv = 0;
    repeat (8) begin
      step(); neg();
      if (host_valid) hv++;
    end
    chk("E_no_host_valid", hv, 0);

    // Reset in the middle of a drain.
    chk("F_overflow_sticky", wr_overflow, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(); drive_prv(300 + i, golden[300 + i]); drive_wr(50 + i, 'h50 + i, i == 0); neg();
    end
    step(); idle(); neg(); chk("F_drain_started", sram_we, 1'b1);
    step(); #1;
    HRESETn = 1'b0;
    #1;
    chk_reset_outputs("rst1");
    step(); step();
    HRESETn = 1'b1;
    nwe = 0;
    repeat (10) begin
      neg();
      if (sram_we) nwe++;
    end
    chk("F_no_we_after_reset", nwe, 0);
    chk("F_pending_low", wr_pending, 1'b0);

    chk("end_wr_queue", wr_exp.size(), 0);
    chk("end_prv_queue", prv_exp.size(), 0);
    chk("end_host_queue", host_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
